// File: rtl/csi_acq_pkg.sv
// csi_acq_pkg: state encoding, default parameters and a saturating-increment helper
// shared by the CSI acquisition sequencer.
package csi_acq_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEARCH    = 3'd1,
    WAIT_LONG = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4,
    HOLDOFF   = 3'd5
  } acq_state_t;
  localparam int unsigned CAPTURE_LEN_DEF  = 128;
  localparam int unsigned LONG_TIMEOUT_DEF = 320;
  localparam int unsigned HOLDOFF_DEF      = 64;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned STATS_W          = 16;
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v, input logic en);
    return v + STATS_W'(en && v != '1);
  endfunction
endpackage

// File: rtl/csi_acq_ctrl_sample_counter.sv
// sample_counter: valid-gated saturating counter with synchronous clear-load and a
// terminal-count flag that is high while the count equals TERM-1.
module sample_counter
  import csi_acq_pkg::*;
#(
  parameter int unsigned W    = CNT_W_DEF,
  parameter int unsigned TERM = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  localparam logic [W-1:0] LAST = W'(TERM == 0 ? 0 : TERM - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == LAST;
endmodule

// File: rtl/csi_acq_ctrl.sv
// csi_acq_ctrl: CSI acquisition sequencer (search, long-preamble wait, capture, host handoff, holdoff).
// Define CSI_ACQ_STATS_EN to add saturating frame/timeout/abort counters.
module csi_acq_ctrl
  import csi_acq_pkg::*;
#(
  parameter int unsigned CAPTURE_LEN  = CAPTURE_LEN_DEF,
  parameter int unsigned LONG_TIMEOUT = LONG_TIMEOUT_DEF,
  parameter int unsigned HOLDOFF      = HOLDOFF_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           enable_in,
  input  logic                           sample_in_valid,
  input  logic                           short_detected_in,
  input  logic                           long_detected_in,
  input  logic                           frame_ack_in,
  output logic                           det_rst_out,
  output logic                           capture_we_out,
  output logic [$clog2(CAPTURE_LEN)-1:0] capture_addr_out,
  output logic                           frame_done_out,
  output logic                           timeout_out,
  output logic [2:0]                     state_out
`ifdef CSI_ACQ_STATS_EN
  ,
  output logic [STATS_W-1:0]             frames_out,
  output logic [STATS_W-1:0]             timeouts_out,
  output logic [STATS_W-1:0]             aborts_out
`endif
);
  localparam int unsigned AW = $clog2(CAPTURE_LEN);
  acq_state_t state_q, state_d;
  logic we_d, tmo_d;
  logic det_rst_q, we_q, done_q, tmo_q;
  logic [AW-1:0] addr_q, addr_cnt;
  logic [CNT_W-1:0] tmo_cnt, hold_cnt;
  logic tmo_tc, addr_tc, hold_tc;
  logic unused_cnt;
  assign unused_cnt = ^{tmo_cnt, hold_cnt};
  sample_counter #(.W(CNT_W), .TERM(LONG_TIMEOUT)) u_tmo_cnt (
    .clk_i(clk_in), .rst_n_i(rst_n_in),
    .load_i(state_q != WAIT_LONG || short_detected_in), .inc_i(sample_in_valid),
    .cnt_o(tmo_cnt), .tc_o(tmo_tc)
  );
  // Address counter is exactly AW bits wide, so it saturates on the last index.
  sample_counter #(.W(AW), .TERM(CAPTURE_LEN)) u_addr_cnt (
    .clk_i(clk_in), .rst_n_i(rst_n_in),
    .load_i(state_q != CAPTURE), .inc_i(sample_in_valid),
    .cnt_o(addr_cnt), .tc_o(addr_tc)
  );
  sample_counter #(.W(CNT_W), .TERM(HOLDOFF)) u_hold_cnt (
    .clk_i(clk_in), .rst_n_i(rst_n_in),
    .load_i(state_q != csi_acq_pkg::HOLDOFF), .inc_i(sample_in_valid),
    .cnt_o(hold_cnt), .tc_o(hold_tc)
  );
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE:      state_d = enable_in ? SEARCH : IDLE;
      SEARCH:    state_d = short_detected_in ? WAIT_LONG : SEARCH;
      WAIT_LONG: begin
        tmo_d   = !long_detected_in && !short_detected_in && sample_in_valid && tmo_tc;
        state_d = long_detected_in ? CAPTURE : tmo_d ? SEARCH : WAIT_LONG;
      end
      CAPTURE: begin
        we_d    = sample_in_valid;
        state_d = (sample_in_valid && addr_tc) ? DONE : CAPTURE;
      end
      DONE:      state_d = !frame_ack_in ? DONE : !enable_in ? IDLE :
                           (HOLDOFF == 0) ? SEARCH : csi_acq_pkg::HOLDOFF;
      csi_acq_pkg::HOLDOFF:
                 state_d = (sample_in_valid && hold_tc) ? SEARCH : csi_acq_pkg::HOLDOFF;
      default:   state_d = IDLE;
    endcase
    // A finished frame survives enable loss until the host acks it.
    if (!enable_in && state_q != DONE) begin
      state_d = IDLE;
      we_d    = 1'b0;
      tmo_d   = 1'b0;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q   <= IDLE;
      det_rst_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      det_rst_q <= !(state_d == SEARCH || state_d == WAIT_LONG) || tmo_d;
      we_q      <= we_d;
      addr_q    <= we_d ? addr_cnt : (state_d == CAPTURE || state_d == DONE) ? addr_q : '0;
      done_q    <= state_d == DONE;
      tmo_q     <= tmo_d;
    end
  assign state_out        = state_q;
  assign det_rst_out      = det_rst_q;
  assign capture_we_out   = we_q;
  assign capture_addr_out = addr_q;
  assign frame_done_out   = done_q;
  assign timeout_out      = tmo_q;
`ifdef CSI_ACQ_STATS_EN
  logic [STATS_W-1:0] frames_q, timeouts_q, aborts_q;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      frames_q   <= '0;
      timeouts_q <= '0;
      aborts_q   <= '0;
    end else begin
      frames_q   <= sat_inc(frames_q, state_d == DONE && state_q != DONE);
      timeouts_q <= sat_inc(timeouts_q, tmo_d);
      aborts_q   <= sat_inc(aborts_q, !enable_in && (state_q == WAIT_LONG || state_q == CAPTURE));
    end
  assign frames_out   = frames_q;
  assign timeouts_out = timeouts_q;
  assign aborts_out   = aborts_q;
`endif
endmodule

// File: tb/tb_csi_acq_ctrl.sv
// tb_csi_acq_ctrl: directed vector table, hand-written corner sequences and randomized
// traffic checked against a behavioural model of the acquisition sequencer.
module tb_csi_acq_ctrl;
  localparam int CL = 8, LT = 16, HO = 4, AW = 3;
  logic clk_in = 0, rst_n_in = 0, enable_in = 0, sample_in_valid = 0;
  logic short_detected_in = 0, long_detected_in = 0, frame_ack_in = 0;
  logic det_rst_out, capture_we_out, frame_done_out, timeout_out;
  logic [AW-1:0] capture_addr_out;
  logic [2:0] state_out;
`ifdef CSI_ACQ_STATS_EN
  logic [15:0] frames_out, timeouts_out, aborts_out;
`endif
  int errors = 0, checks = 0;

  csi_acq_ctrl #(.CAPTURE_LEN(CL), .LONG_TIMEOUT(LT), .HOLDOFF(HO), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
    .sample_in_valid(sample_in_valid), .short_detected_in(short_detected_in),
    .long_detected_in(long_detected_in), .frame_ack_in(frame_ack_in),
    .det_rst_out(det_rst_out), .capture_we_out(capture_we_out),
    .capture_addr_out(capture_addr_out), .frame_done_out(frame_done_out),
    .timeout_out(timeout_out), .state_out(state_out)
`ifdef CSI_ACQ_STATS_EN
    , .frames_out(frames_out), .timeouts_out(timeouts_out), .aborts_out(aborts_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit en, v, sh, lg, ak;
    int st, we, addr, done, to, det;
  } vec_t;
  vec_t tbl[64];
  int n = 0;

  task automatic add(input bit en, v, sh, lg, ak, input int st, we, addr, done, to, det);
    tbl[n] = '{en, v, sh, lg, ak, st, we, addr, done, to, det};
    n++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input int st, we, addr, done, to, det);
    chk({tag, ".state"}, int'(state_out), st);
    chk({tag, ".we"}, int'(capture_we_out), we);
    chk({tag, ".addr"}, int'(capture_addr_out), addr);
    chk({tag, ".done"}, int'(frame_done_out), done);
    chk({tag, ".timeout"}, int'(timeout_out), to);
    chk({tag, ".det_rst"}, int'(det_rst_out), det);
  endtask

  task automatic drive(input bit en, v, sh, lg, ak);
    enable_in = en; sample_in_valid = v; short_detected_in = sh;
    long_detected_in = lg; frame_ack_in = ak;
  endtask

  // Behavioural model: phase number plus plain event counts since phase entry.
  int m_st, m_wait, m_wr, m_hold;
  int e_st, e_we, e_addr, e_done, e_to, e_det;

  task automatic model_reset();
    m_st = 0; m_wait = 0; m_wr = 0; m_hold = 0;
    e_st = 0; e_we = 0; e_addr = 0; e_done = 0; e_to = 0; e_det = 1;
  endtask

  task automatic model(input bit en, v, sh, lg, ak);
    int ns, idx;
    bit we, to;
    ns = m_st; we = 0; to = 0; idx = 0;
    if (m_st == 0) ns = en ? 1 : 0;
    else if (m_st == 1) begin
      if (sh) begin ns = 2; m_wait = 0; end
    end else if (m_st == 2) begin
      if (lg) begin ns = 3; m_wr = 0; end
      else if (sh) m_wait = 0;
      else if (v) begin
        m_wait++;
        if (m_wait == LT) begin ns = 1; to = 1; end
      end
    end else if (m_st == 3) begin
      if (v) begin
        we = 1; idx = m_wr; m_wr++;
        if (m_wr == CL) ns = 4;
      end
    end else if (m_st == 4) begin
      if (ak) begin ns = !en ? 0 : (HO == 0 ? 1 : 5); m_hold = 0; end
    end else begin
      if (v) begin
        m_hold++;
        if (m_hold == HO) ns = 1;
      end
    end
    if (!en && m_st != 4) begin ns = 0; we = 0; to = 0; end
    e_st = ns; e_we = we; e_to = to; e_done = (ns == 4);
    e_det = (ns != 1 && ns != 2) || to;
    e_addr = we ? idx : ((ns == 3 || ns == 4) ? e_addr : 0);
    m_st = ns;
  endtask

  task automatic cyc(input bit en, v, sh, lg, ak);
    drive(en, v, sh, lg, ak);
    model(en, v, sh, lg, ak);
    @(posedge clk_in); #1;
    cmp_all("mdl", e_st, e_we, e_addr, e_done, e_to, e_det);
  endtask

  initial begin
    int wr;
    bit v;
    // Directed table: timeout, coincidence, full frame, ack, holdoff, stray ack.
    add(1,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,1,0,0, 2,0,0,0,0,0);
    for (int i = 1; i < LT; i++) add(1,1,0,0,0, 2,0,0,0,0,0);
    add(1,1,0,0,0, 1,0,0,0,1,1);
    add(1,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,1,0,0, 2,0,0,0,0,0);
    for (int i = 1; i < LT; i++) add(1,1,0,0,0, 2,0,0,0,0,0);
    add(1,1,0,1,0, 3,0,0,0,0,1);
    for (int i = 0; i < CL; i++) add(1,1,0,0,0, i == CL-1 ? 4 : 3, 1, i, i == CL-1, 0, 1);
    add(1,1,0,0,0, 4,0,CL-1,1,0,1);
    add(1,0,0,0,1, 5,0,0,0,0,1);
    for (int i = 1; i < HO; i++) add(1,1,0,0,0, 5,0,0,0,0,1);
    add(1,1,0,0,0, 1,0,0,0,0,0);
    add(1,0,0,0,1, 1,0,0,0,0,0);

    #12;
    cmp_all("reset", 0, 0, 0, 0, 0, 1);
    rst_n_in = 1;
    for (int i = 0; i < n; i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].sh, tbl[i].lg, tbl[i].ak);
      @(posedge clk_in); #1;
      cmp_all($sformatf("tbl%0d", i), tbl[i].st, tbl[i].we, tbl[i].addr,
              tbl[i].done, tbl[i].to, tbl[i].det);
    end

    rst_n_in = 0; drive(0,0,0,0,0); #2; rst_n_in = 1;
    model_reset();

    // Abort after three writes, then a fresh capture from address 0.
    cyc(1,0,0,0,0); cyc(1,0,1,0,0);
    repeat (3) cyc(1,1,0,0,0);
    cyc(1,0,0,1,0);
    repeat (3) cyc(1,1,0,0,0);
    cyc(0,0,0,0,0);
    chk("abort_state", int'(state_out), 0);
    chk("abort_done", int'(frame_done_out), 0);
    chk("abort_addr", int'(capture_addr_out), 0);
    cyc(1,0,0,0,0); cyc(1,0,1,0,0); cyc(1,0,0,1,0); cyc(1,1,0,0,0);
    chk("fresh_we", int'(capture_we_out), 1);
    chk("fresh_addr", int'(capture_addr_out), 0);
    repeat (CL-1) cyc(1,1,0,0,0);
    chk("done_set", int'(frame_done_out), 1);

    // Enable dropped in DONE: frame held until ack, then IDLE.
    repeat (5) begin
      cyc(0,1,0,0,0);
      chk("done_hold", int'(frame_done_out), 1);
    end
    cyc(0,0,0,0,1);
    chk("ack_idle_state", int'(state_out), 0);
    chk("ack_idle_done", int'(frame_done_out), 0);

    // Sparse valids during capture.
    cyc(1,0,0,0,0); cyc(1,0,1,0,0); cyc(1,0,0,1,0);
    wr = 0;
    for (int i = 0; i < 12; i++) begin
      v = (i % 3 == 0);
      cyc(1,v,0,0,0);
      chk("gap_we", int'(capture_we_out), int'(v));
      if (v) begin
        chk("gap_addr", int'(capture_addr_out), wr);
        wr++;
      end
    end

    // Asynchronous reset mid-capture.
    cyc(1,1,0,0,0);
    #2 rst_n_in = 0;
    #1;
    chk("arst_we", int'(capture_we_out), 0);
    chk("arst_state", int'(state_out), 0);
    chk("arst_det", int'(det_rst_out), 1);
    @(posedge clk_in); #1;
    chk("arst_nowrite", int'(capture_we_out), 0);
    rst_n_in = 1;
    model_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 99) < 97, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
